div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for MIPS DIV/DIVU in the EX stage.
- Sits directly upstream of the HI/LO write-data 2:1 muxes.
  - quotient feeds the LO-side mux input; remainder feeds the HI-side mux input.
  - The other mux input carries the multiplier result.
- `busy` drives the pipeline stall logic; `done` qualifies the HI/LO write enable.
- Radix-2 restoring algorithm on magnitudes, with a sign fix-up on the final iteration.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is verified.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- start  input  1  request a divide. Sampled only in IDLE or FIN.
- is_signed  input  1  1 = DIV, 0 = DIVU. Sampled with start.
- dividend  input  32  numerator. Sampled with start.
- divisor  input  32  denominator. Sampled with start.
- cancel  input  1  pipeline flush. Aborts any operation.
- busy  output  1  high while iterating; stall request.
- done  output  1  one-cycle pulse; results valid and new.
- quotient  output  32  registered quotient (to LO mux)
- remainder  output  32  registered remainder (to HI mux)
- div_by_zero  output  1  registered flag; divisor was 0 for the last completed op

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter=0.
  - Reset overrides everything, including mid-operation.
- States: IDLE, RUN, FIN. All outputs are registered.
- IDLE:
  - start=1 & cancel=0 & divisor!=0 → RUN.
    - Latch |dividend| and |divisor| (magnitudes only when is_signed=1).
    - Latch the quotient sign (dividend[31]^divisor[31]) and remainder sign (dividend[31]), both gated by is_signed.
    - Clear the 33-bit partial remainder; counter=31.
  - start=1 & cancel=0 & divisor==0 → FIN directly.
    - quotient=32'hFFFFFFFF, remainder=dividend (unmodified), div_by_zero=1.
    - The same values are used for both signed and unsigned.
- RUN (busy=1), one iteration per clock:
  - Shift next dividend bit into the partial remainder.
  - Trial-subtract the divisor magnitude; restore if negative; shift the quotient bit in.
  - counter decrements; leave on the edge where counter==0.
  - On exit → FIN: write sign-corrected quotient/remainder and set div_by_zero=0.
    - Quotient is two's-complement negated if the quotient sign is set.
    - Remainder is negated if the remainder sign is set.
- FIN (done=1, busy=0):
  - Lasts one cycle, then → IDLE, unless start=1 & cancel=0 (back-to-back accept, same rules as IDLE).
- Latency:
  - Start sampled at edge E0 → busy=1 after E0 through E32 → done=1 in the cycle after E32 (33 cycles).
  - Divide-by-zero: done=1 in the cycle after E0.
- Hold: quotient, remainder and div_by_zero hold their values until the next completion. They are unchanged by IDLE, RUN or cancel.
- start while in RUN: ignored. No queueing.
- cancel:
  - Any state → IDLE at the next edge; busy=0, done=0.
  - Results are not updated.
  - cancel wins over a simultaneous start.
- Signed overflow (0x80000000 / -1): quotient=0x80000000, remainder=0. This falls out of the magnitude path.
- Sign rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend; a zero remainder is never negated to nonzero.
- Inputs are not required to stay stable after the start cycle.

Test Plan:
- DIVU 100/7: start at E0 → busy high 32 cycles; done pulse in cycle after E32; quotient=14, remainder=2, div_by_zero=0.
- DIV -7/2 (0xFFFFFFF9/2) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also DIV 7/-2 → quotient=0xFFFFFFFD, remainder=1. Also DIV 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0.
- DIVU 5/0 → done in cycle after E0, busy never high; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. A following DIVU 9/3 → quotient=3, remainder=0, div_by_zero=0.
- Start 100/7, assert cancel at E10 → busy=0 and done never pulses; quotient/remainder keep prior values. start+cancel together in IDLE → stays IDLE.
- Start while busy at E5 with different operands → ignored; the first result is delivered. start in FIN cycle → back-to-back accept; second done exactly 33 cycles later.
- rst=0 at E15 mid-op → all outputs 0 next cycle, state IDLE; start after release gives a correct result (0xFFFFFFFF/0x10 DIVU → quotient=0x0FFFFFFF, remainder=0xF).

Source files
------------

// File: rtl/div_unit_if.sv
// Handshake and result bundle between the EX-stage pipeline and the integer divider.
// The master is the pipeline side; the slave is the divider.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor, cancel,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, cancel,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Works on operand magnitudes and applies the sign fix-up while writing the final result.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t state, state_next;
    logic   load, load_zero, finish;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] dvd, dvs;
    logic             q_neg, r_neg;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] quo_q, rem_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted, diff, prem_next;
    logic             qbit;
    logic [WIDTH-1:0] dvd_next, q_fin, r_fin;

    assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];
    assign mag_a = a_neg ? -bus.dividend : bus.dividend;
    assign mag_b = b_neg ? -bus.divisor  : bus.divisor;

    // The dividend register doubles as the quotient register: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    assign shifted   = {prem[WIDTH-1:0], dvd[WIDTH-1]};
    assign diff      = shifted - {1'b0, dvs};
    assign qbit      = ~diff[WIDTH];
    assign prem_next = qbit ? diff : shifted;
    assign dvd_next  = {dvd[WIDTH-2:0], qbit};

    // Negating zero yields zero, so a zero remainder never turns nonzero.
    assign q_fin = q_neg ? -dvd_next : dvd_next;
    assign r_fin = r_neg ? -prem_next[WIDTH-1:0] : prem_next[WIDTH-1:0];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next = state;
        load       = 1'b0;
        load_zero  = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE, FIN: begin
                state_next = IDLE;
                if (bus.start && !bus.cancel) begin
                    if (bus.divisor == '0) begin
                        state_next = FIN;
                        load_zero  = 1'b1;
                    end else begin
                        state_next = RUN;
                        load       = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = FIN;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next == RUN);
            done_q <= (state_next == FIN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            prem  <= '0;
            dvd   <= '0;
            dvs   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            if (load) begin
                dvd   <= mag_a;
                dvs   <= mag_b;
                q_neg <= a_neg ^ b_neg;
                r_neg <= a_neg;
                prem  <= '0;
                cnt   <= CNT_W'(WIDTH - 1);
            end else if (state == RUN && !bus.cancel) begin
                prem <= prem_next;
                dvd  <= dvd_next;
                if (cnt != '0) cnt <= cnt - 1'b1;
            end

            // Results change only on completion; cancel and idle cycles hold them.
            if (load_zero) begin
                quo_q <= '1;
                rem_q <= bus.dividend;
                dbz_q <= 1'b1;
            end else if (finish) begin
                quo_q <= q_fin;
                rem_q <= r_fin;
                dbz_q <= 1'b0;
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, sign rules, divide-by-zero,
// cancel, ignored start, back-to-back accept and mid-operation reset.
module tb_div_unit;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives start for exactly one rising edge, then scrambles the operands.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.cancel    = 1'b0;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.is_signed = ~sgn;
        bus.dividend  = 32'hDEAD_BEEF;
        bus.divisor   = 32'h1234_5678;
    endtask

    // Counts busy cycles (bounded), leaving the bench in the cycle after busy falls.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input logic exp_dz, input int exp_cyc);
        int cyc;
        issue(sgn, a, b);
        wait_done(cyc);
        check({tag, ".busy_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, ".done"}, {31'b0, bus.done}, 32'd1);
        check({tag, ".quotient"}, bus.quotient, exp_q);
        check({tag, ".remainder"}, bus.remainder, exp_r);
        check({tag, ".div_by_zero"}, {31'b0, bus.div_by_zero}, {31'b0, exp_dz});
        @(negedge clk);
        check({tag, ".done_low"}, {31'b0, bus.done}, 32'd0);
        check({tag, ".busy_low"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        int  cyc;
        logic seen_done;

        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.cancel    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.busy", {31'b0, bus.busy}, 32'd0);
        check("reset.done", {31'b0, bus.done}, 32'd0);
        check("reset.quotient", bus.quotient, 32'd0);
        check("reset.remainder", bus.remainder, 32'd0);
        check("reset.div_by_zero", {31'b0, bus.div_by_zero}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 32);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32);
        run_op("div_m8_m4", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'd2, 32'd0, 1'b0, 32);
        run_op("divu_big", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 32);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
        run_op("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 0);
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32);

        // Cancel at the tenth edge after start: nothing completes, results hold.
        issue(1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel.busy", {31'b0, bus.busy}, 32'd0);
        check("cancel.done", {31'b0, bus.done}, 32'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        check("cancel.no_activity", {31'b0, seen_done}, 32'd0);
        check("cancel.quotient_hold", bus.quotient, 32'd3);
        check("cancel.remainder_hold", bus.remainder, 32'd0);

        // start together with cancel in IDLE must not launch anything.
        bus.start    = 1'b1;
        bus.cancel   = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check("start_cancel.busy", {31'b0, bus.busy}, 32'd0);
        check("start_cancel.done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        check("start_cancel.busy2", {31'b0, bus.busy}, 32'd0);

        // A second start during RUN is ignored; the first result is delivered.
        issue(1'b0, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd200;
        bus.divisor  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc);
        check("ignore.busy_cycles", 32'(cyc), 32'd27);
        check("ignore.done", {31'b0, bus.done}, 32'd1);
        check("ignore.quotient", bus.quotient, 32'd14);
        check("ignore.remainder", bus.remainder, 32'd2);

        // Back-to-back: start in the FIN cycle; second done 33 cycles after the first.
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        check("b2b.done_gone", {31'b0, bus.done}, 32'd0);
        check("b2b.busy", {31'b0, bus.busy}, 32'd1);
        wait_done(cyc);
        check("b2b.busy_cycles", 32'(cyc), 32'd32);
        check("b2b.done", {31'b0, bus.done}, 32'd1);
        check("b2b.quotient", bus.quotient, 32'hFFFF_FFFD);
        check("b2b.remainder", bus.remainder, 32'hFFFF_FFFF);
        @(negedge clk);

        // Reset at the fifteenth edge of an operation clears everything.
        issue(1'b0, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midreset.busy", {31'b0, bus.busy}, 32'd0);
        check("midreset.done", {31'b0, bus.done}, 32'd0);
        check("midreset.quotient", bus.quotient, 32'd0);
        check("midreset.remainder", bus.remainder, 32'd0);
        check("midreset.div_by_zero", {31'b0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        run_op("post_reset", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
